// File: rtl/cr_axi4s_slv_pkt.sv
// AXI4-Stream ingress buffer: registered input stage into a show-ahead FIFO.
// Define CR_AXI4S_SLV_PKT_MODE_EN for store-and-forward packet mode.
module cr_axi4s_slv_pkt #(
    parameter int DATA_W       = 64,
    parameter int USER_W       = 8,
    parameter int N_ENTRIES    = 16,
    parameter int N_AFULL_VAL  = 1,
    parameter int N_AEMPTY_VAL = 1,
    localparam int CW = $clog2(N_ENTRIES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [USER_W-1:0] s_tuser,
    input  logic              s_tlast,
    input  logic              slv_rd,
    output logic [DATA_W-1:0] slv_tdata,
    output logic [USER_W-1:0] slv_tuser,
    output logic              slv_tlast,
    output logic              slv_empty,
    output logic              slv_aempty,
    output logic [CW-1:0]     slv_used,
    output logic [CW-1:0]     slv_pkt_cnt,
    output logic              slv_ovfl
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam logic [CW-1:0] FULL_LVL = CW'(N_ENTRIES);
    localparam logic [CW-1:0] RDY_LVL  = CW'(N_ENTRIES - N_AFULL_VAL);
    localparam logic [CW-1:0] AE_LVL   = CW'(N_AEMPTY_VAL);

    logic [DATA_W-1:0]    mem_data [N_ENTRIES];
    logic [USER_W-1:0]    mem_user [N_ENTRIES];
    logic [N_ENTRIES-1:0] mem_last;

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     used, used_nxt;
    logic [CW-1:0]     pkt_cnt, pkt_nxt;
    logic [CW-1:0]     level;
    logic              in_vld, in_last;
    logic [DATA_W-1:0] in_data;
    logic [USER_W-1:0] in_user;
    logic              wr, pop, head_last, empty, accept;
    logic              wr_last, pop_last;

    // level includes the in-flight beat so the FIFO can never overflow
    assign level     = used + CW'(in_vld);
    assign s_tready  = (level < RDY_LVL);
    assign accept    = s_tvalid & s_tready;
    assign wr        = in_vld;
    assign head_last = mem_last[rd_ptr];
    assign pop       = slv_rd & ~empty;
    assign wr_last   = wr & in_last;
    assign pop_last  = pop & head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld  <= 1'b0;
            in_data <= '0;
            in_user <= '0;
            in_last <= 1'b0;
        end else begin
            in_vld <= accept;
            if (accept) begin
                in_data <= s_tdata;
                in_user <= s_tuser;
                in_last <= s_tlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_data[wr_ptr] <= in_data;
            mem_user[wr_ptr] <= in_user;
            mem_last[wr_ptr] <= in_last;
        end
    end

    always_comb begin
        used_nxt = used;
        pkt_nxt  = pkt_cnt;
        case ({wr, pop})
            2'b10:   used_nxt = used + CW'(1);
            2'b01:   used_nxt = used - CW'(1);
            default: used_nxt = used;
        endcase
        case ({wr_last, pop_last})
            2'b10:   pkt_nxt = pkt_cnt + CW'(1);
            2'b01:   pkt_nxt = pkt_cnt - CW'(1);
            default: pkt_nxt = pkt_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            used    <= '0;
            pkt_cnt <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            used    <= used_nxt;
            pkt_cnt <= pkt_nxt;
        end
    end

`ifdef CR_AXI4S_SLV_PKT_MODE_EN
    logic cut, cut_set, ovfl_q;

    // a packet that cannot fit is released beat by beat
    assign cut_set = (used == FULL_LVL) && (pkt_cnt == '0) && !cut;
    assign empty   = cut ? (used == '0) : (pkt_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cut    <= 1'b0;
            ovfl_q <= 1'b0;
        end else begin
            ovfl_q <= cut_set;
            if (cut_set)
                cut <= 1'b1;
            else if (pop_last)
                cut <= 1'b0;
        end
    end

    assign slv_ovfl = ovfl_q;
`else
    assign empty    = (used == '0);
    assign slv_ovfl = 1'b0;
`endif

    assign slv_empty   = empty;
    assign slv_aempty  = (used <= AE_LVL);
    assign slv_used    = used;
    assign slv_pkt_cnt = pkt_cnt;
    assign slv_tdata   = empty ? '0 : mem_data[rd_ptr];
    assign slv_tuser   = empty ? '0 : mem_user[rd_ptr];
    assign slv_tlast   = empty ? 1'b0 : head_last;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n)
            assert (!(wr && used == FULL_LVL))
            else $fatal(1, "cr_axi4s_slv_pkt: write into full FIFO");
    end
`endif

endmodule

// File: tb/tb_cr_axi4s_slv_pkt.sv
// Bench for cr_axi4s_slv_pkt: directed and random traffic against a queue model.
// Define CR_AXI4S_SLV_PKT_MODE_EN to exercise store-and-forward mode.
`timescale 1ns/1ps
module tb_cr_axi4s_slv_pkt;

`ifdef CR_AXI4S_SLV_PKT_MODE_EN
    localparam bit PKT = 1'b1;
    localparam int AF  = 0;
`else
    localparam bit PKT = 1'b0;
    localparam int AF  = 1;
`endif
    localparam int N  = 16;
    localparam int DW = 16;
    localparam int UW = 4;
    localparam int AE = 1;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tlast = 1'b0;
    logic          slv_rd = 1'b0;
    logic [DW-1:0] slv_tdata;
    logic [UW-1:0] slv_tuser;
    logic          slv_tlast;
    logic          slv_empty;
    logic          slv_aempty;
    logic [CW-1:0] slv_used;
    logic [CW-1:0] slv_pkt_cnt;
    logic          slv_ovfl;

    cr_axi4s_slv_pkt #(
        .DATA_W(DW), .USER_W(UW), .N_ENTRIES(N),
        .N_AFULL_VAL(AF), .N_AEMPTY_VAL(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .slv_rd(slv_rd),
        .slv_tdata(slv_tdata), .slv_tuser(slv_tuser), .slv_tlast(slv_tlast),
        .slv_empty(slv_empty), .slv_aempty(slv_aempty),
        .slv_used(slv_used), .slv_pkt_cnt(slv_pkt_cnt), .slv_ovfl(slv_ovfl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t         fq[$];
    beat_t         pend;
    bit            pend_v, m_cut, m_ovfl, last_acc;
    logic [DW-1:0] got[$];
    int            tests, fails, ovfl_seen, cyc_n, first_pop, last_pop;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pcnt();
        int c = 0;
        foreach (fq[i]) c += int'(fq[i].l);
        return c;
    endfunction

    // One clock: compare DUT against the queue model, then advance both.
    task automatic cyc();
        int used = fq.size();
        int pc   = pcnt();
        bit emp  = (PKT && !m_cut) ? (pc == 0) : (used == 0);
        bit rdy  = (used + int'(pend_v)) < (N - AF);
        bit pop, set;
        chk("used", 64'(slv_used), 64'(used));
        chk("pkt_cnt", 64'(slv_pkt_cnt), 64'(pc));
        chk("empty", 64'(slv_empty), 64'(emp));
        chk("ready", 64'(s_tready), 64'(rdy));
        chk("aempty", 64'(slv_aempty), 64'(used <= AE));
        chk("ovfl", 64'(slv_ovfl), 64'(m_ovfl));
        if (m_ovfl) ovfl_seen++;
        pop = slv_rd && !emp;
        set = PKT && used == N && pc == 0 && !m_cut;
        last_acc = s_tvalid && rdy;
        if (pop) begin
            chk("head_data", 64'(slv_tdata), 64'(fq[0].d));
            chk("head_user", 64'(slv_tuser), 64'(fq[0].u));
            chk("head_last", 64'(slv_tlast), 64'(fq[0].l));
            if (got.size() == 0) first_pop = cyc_n;
            last_pop = cyc_n;
            got.push_back(fq[0].d);
            if (fq[0].l) m_cut = 1'b0;
            void'(fq.pop_front());
        end
        if (set) m_cut = 1'b1;
        m_ovfl = set;
        if (pend_v) fq.push_back(pend);
        pend_v = last_acc;
        pend = {s_tdata, s_tuser, s_tlast};
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        slv_rd = 1'b0;
        #1;
        chk("rst_ready", 64'(s_tready), 64'(1));
        chk("rst_empty", 64'(slv_empty), 64'(1));
        chk("rst_aempty", 64'(slv_aempty), 64'(1));
        chk("rst_ovfl", 64'(slv_ovfl), 64'(0));
        chk("rst_used", 64'(slv_used), 64'(0));
        chk("rst_pkt", 64'(slv_pkt_cnt), 64'(0));
        chk("rst_tdata", 64'(slv_tdata), 64'(0));
        chk("rst_tuser", 64'(slv_tuser), 64'(0));
        chk("rst_tlast", 64'(slv_tlast), 64'(0));
        fq.delete();
        got.delete();
        pend_v = 1'b0;
        m_cut = 1'b0;
        m_ovfl = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(int n, int base, bit end_last);
        int i = 0;
        for (int k = 0; k < 300 && i < n; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(base + i);
            s_tuser  = UW'(base + i);
            s_tlast  = end_last && (i == n - 1);
            cyc();
            if (last_acc) i++;
        end
        s_tvalid = 1'b0;
        chk("send_done", 64'(i), 64'(n));
    endtask

    task automatic drain(int budget);
        slv_rd = 1'b1;
        s_tvalid = 1'b0;
        for (int k = 0; k < budget && (fq.size() != 0 || pend_v); k++)
            cyc();
        chk("drain_used", 64'(slv_used), 64'(0));
        chk("drain_left", 64'(fq.size() + int'(pend_v)), 64'(0));
    endtask

    task automatic rd_empty_a5();
        slv_rd = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) cyc();
        slv_rd = 1'b0;
        got.delete();
        send(1, 'hA5, 1'b1);
        drain(20);
        chk("a5_count", 64'(got.size()), 64'(1));
        if (got.size() > 0)
            chk("a5_data", 64'(got[0]), 64'('hA5));
    endtask

    initial begin
        int sent;
        int u_ref;

        do_reset();
        rd_empty_a5();

        // fill with single-beat packets, no reads
        got.delete();
        sent = 0;
        slv_rd = 1'b0;
        s_tlast = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_tvalid = (sent < 16);
            s_tdata = DW'(sent);
            s_tuser = UW'(sent);
            cyc();
            if (last_acc) sent++;
        end
        chk("fill_used", 64'(slv_used), 64'(N - AF));
        chk("fill_pkt", 64'(slv_pkt_cnt), 64'(N - AF));
        chk("fill_ready", 64'(s_tready), 64'(0));
        slv_rd = 1'b1;
        for (int k = 0; k < 80 && got.size() < 16; k++) begin
            s_tvalid = (sent < 16);
            s_tdata = DW'(sent);
            s_tuser = UW'(sent);
            cyc();
            if (last_acc) sent++;
        end
        s_tvalid = 1'b0;
        drain(40);
        chk("fill_count", 64'(got.size()), 64'(16));
        foreach (got[i]) chk("fill_order", 64'(got[i]), 64'(i));

        rd_empty_a5();

        // full FIFO, then read and write held for 100 cycles
        got.delete();
        sent = 0;
        u_ref = 0;
        slv_rd = 1'b0;
        s_tlast = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_tvalid = 1'b1;
            s_tdata = DW'(sent);
            s_tuser = UW'(sent);
            cyc();
            if (last_acc) sent++;
        end
        slv_rd = 1'b1;
        for (int k = 0; k < 100; k++) begin
            s_tdata = DW'(sent);
            s_tuser = UW'(sent);
            cyc();
            if (last_acc) sent++;
            if (k == 5) u_ref = int'(slv_used);
            if (k > 5) chk("fr_used_const", 64'(slv_used), 64'(u_ref));
        end
        chk("fr_pops", 64'(got.size()), 64'(100));
        foreach (got[i]) chk("fr_order", 64'(got[i]), 64'(i));
        drain(60);

        // random traffic
        s_tvalid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!s_tvalid || last_acc) begin
                s_tvalid = ($urandom_range(3) != 0);
                s_tdata  = DW'($urandom);
                s_tuser  = UW'($urandom);
                s_tlast  = PKT ? ($urandom_range(6) == 0) : ($urandom_range(1) == 1);
            end
            slv_rd = ($urandom_range(2) != 0);
            cyc();
        end
        send(1, 'h3C, 1'b1);
        drain(200);

`ifdef CR_AXI4S_SLV_PKT_MODE_EN
        // 4-beat packet with a gap before tlast
        got.delete();
        slv_rd = 1'b1;
        send(3, 'h10, 1'b0);
        repeat (3) cyc();
        send(1, 'h13, 1'b1);
        drain(20);
        chk("pk4_count", 64'(got.size()), 64'(4));
        foreach (got[i]) chk("pk4_order", 64'(got[i]), 64'('h10 + i));
        chk("pk4_b2b", 64'(last_pop - first_pop), 64'(3));

        // oversize packet forced to cut-through
        got.delete();
        ovfl_seen = 0;
        slv_rd = 1'b1;
        send(20, 'h100, 1'b1);
        drain(60);
        cyc();
        chk("big_ovfl", 64'(ovfl_seen), 64'(1));
        chk("big_count", 64'(got.size()), 64'(20));
        foreach (got[i]) chk("big_order", 64'(got[i]), 64'('h100 + i));
        chk("big_empty", 64'(slv_empty), 64'(1));
`endif

        // reset in the middle of a packet
        slv_rd = 1'b0;
        send(4, 'h40, 1'b0);
        chk("mid_used", 64'(slv_used), 64'(3));
        #2;
        do_reset();
        got.delete();
        slv_rd = 1'b1;
        send(3, 'h50, 1'b1);
        drain(30);
        chk("post_rst_count", 64'(got.size()), 64'(3));
        foreach (got[i]) chk("post_rst_order", 64'(got[i]), 64'('h50 + i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
